// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: FSM encoding, instruction
// field positions and flag bit positions.
package alu_pkg;

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IMM  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    // Instruction byte layout: [7:5] op, [4:3] rd, [2:1] rs, [0] imm
    localparam int OP_HI   = 7;
    localparam int OP_LO   = 5;
    localparam int RD_HI   = 4;
    localparam int RD_LO   = 3;
    localparam int RS_HI   = 2;
    localparam int RS_LO   = 1;
    localparam int IMM_BIT = 0;

    // Bit positions inside the 2-bit flags word
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 4-entry register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port.
module regfile_4x8
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [1:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear on reset, otherwise write one entry when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the stored value, so a read during a write returns the old data
    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_issue_stage.sv
// Multi-cycle execute sequencer in front of an 8-bit combinational ALU.
// Accepts an instruction byte (plus an optional immediate byte), drives
// registered operands/op to the ALU, then writes the result back.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero_flag,
    input  logic              overflow_flag,
    output logic [1:0]        flags_out,
    output logic              done,
    output logic              busy,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [1:0]        state;
    logic [1:0]        rd_p0;
    logic [DATA_W-1:0] result_p1;
    logic [1:0]        flags_p1;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              accept;
    logic              wb_en;

    // The instruction byte addresses the register file directly so the
    // operands can be loaded on the same edge that accepts it
    regfile_4x8 #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en),
        .waddr    (rd_p0),
        .wdata    (result_p1),
        .raddr1   (instr_in[RD_HI:RD_LO]),
        .rdata1   (rf_rdata1),
        .raddr2   (instr_in[RS_HI:RS_LO]),
        .rdata2   (rf_rdata2),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    assign instr_ready = (state == S_IDLE) || (state == S_IMM);
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != S_IDLE);
    // A reset landing in WB abandons the instruction, so no done pulse
    assign wb_en       = (state == S_WB) && !rst;
    assign done        = wb_en;

    // Sequencer: accept -> (IMM) -> EXEC -> WB -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_p0     <= '0;
            operand1  <= '0;
            operand2  <= '0;
            alu_op    <= '0;
            result_p1 <= '0;
            flags_p1  <= '0;
            flags_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rd_p0    <= instr_in[RD_HI:RD_LO];
                        operand1 <= rf_rdata1;
                        alu_op   <= instr_in[OP_HI:OP_LO];
                        if (instr_in[IMM_BIT]) begin
                            state <= S_IMM;
                        end else begin
                            operand2 <= rf_rdata2;
                            state    <= S_EXEC;
                        end
                    end
                end
                S_IMM: begin
                    if (accept) begin
                        operand2 <= instr_in;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_p1        <= alu_result;
                    flags_p1[FLAG_Z] <= zero_flag;
                    flags_p1[FLAG_V] <= overflow_flag;
                    state            <= S_WB;
                end
                default: begin
                    flags_out <= flags_p1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
